dram_arbiter: RTL and testbench

Shares the single data-RAM port between two requesters: the CPU load/store path (port 0, driven from the EX stage) and a DMA/loader engine (port 1) used to preload or inspect data memory. It sits between the requesters and the DRAM, grants at most one access per cycle, supports locked DMA bursts with a bounded length, and returns read data to the requester that issued the read one cycle later.

---
 rtl/dram_arb_pkg.sv | 21 ++
 rtl/dram_arb_grant.sv | 54 +++++
 rtl/dram_arbiter.sv | 154 +++++++++++++++
 tb/tb_dram_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared definitions for the data-RAM arbiter.
//   state_t  - ownership state of the DRAM port (previous cycle)
//   PORT_*   - bit index of each requester in the one-hot grant vector
//   OP_*     - DRAM access width encodings
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU   = 2'd1,
        ST_DMA   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam logic [1:0] OP_BYTE = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_WORD = 2'b10;

endpackage

// File: rtl/dram_arb_grant.sv
// dram_arb_grant: combinational grant selector for the DRAM arbiter.
// Macro DRAM_ARB_RR_EN: round-robin between the ports (uses last_dma);
// otherwise fixed CPU priority with a starvation override (uses wait_cnt).
// Ports:
//   cpu_valid, dma_valid - requests
//   state                - ownership state from the previous cycle
//   burst_cnt            - locked DMA beats taken so far
//   last_dma / wait_cnt  - RR pointer (1 = DMA granted last) / DMA wait count
//   grant                - one-hot grant, indexed by PORT_CPU / PORT_DMA
module dram_arb_grant
    import dram_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int MAX_WAIT  = 15,
    parameter int BURST_W   = 4,
    parameter int WAIT_W    = 4
) (
    input  logic               cpu_valid,
    input  logic               dma_valid,
    input  state_t             state,
    input  logic [BURST_W-1:0] burst_cnt,
`ifdef DRAM_ARB_RR_EN
    input  logic               last_dma,
`else
    input  logic [WAIT_W-1:0]  wait_cnt,
`endif
    output logic [1:0]         grant
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);
`ifndef DRAM_ARB_RR_EN
    localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);
`endif

    always_comb begin
        grant = '0;
        if (state == ST_BURST && dma_valid && burst_cnt < BURST_LIM) begin
            grant[PORT_DMA] = 1'b1;
`ifdef DRAM_ARB_RR_EN
        end else if (cpu_valid && dma_valid) begin
            if (last_dma) grant[PORT_CPU] = 1'b1;
            else          grant[PORT_DMA] = 1'b1;
`else
        end else if (dma_valid && wait_cnt == WAIT_LIM) begin
            grant[PORT_DMA] = 1'b1;
`endif
        end else if (cpu_valid) begin
            grant[PORT_CPU] = 1'b1;
        end else if (dma_valid) begin
            grant[PORT_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the data-RAM port between the CPU (port 0) and a
// DMA/loader engine (port 1). One access per cycle, locked DMA bursts of at
// most MAX_BURST beats, read data returned one cycle after the read beat.
// Macro DRAM_ARB_RR_EN: round-robin arbitration instead of fixed CPU
// priority with the MAX_WAIT starvation override.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   cpu_* / dma_*                  - request channels (valid/ready/we/op/adr/wdata)
//   dma_lock                       - hold the grant on DMA for the next beat
//   cpu_rvalid, dma_rvalid, rdata  - read response (rdata shared)
//   dram_adr/op/we/wdin, dram_rdo  - DRAM port
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_op,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_rvalid,
    input  logic        dma_valid,
    output logic        dma_ready,
    input  logic        dma_we,
    input  logic [1:0]  dma_op,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] dram_adr,
    output logic [1:0]  dram_op,
    output logic        dram_we,
    output logic [31:0] dram_wdin,
    input  logic [31:0] dram_rdo
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    state_t             state, state_next;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_next, burst_base;
    logic               rd_cpu, rd_dma;
    logic [1:0]         grant_raw, grant;
    logic               cpu_beat, dma_beat;
`ifdef DRAM_ARB_RR_EN
    logic               last_dma, last_dma_next;
`else
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
`endif

    dram_arb_grant #(
        .MAX_BURST (MAX_BURST),
        .MAX_WAIT  (MAX_WAIT),
        .BURST_W   (BURST_W),
        .WAIT_W    (WAIT_W)
    ) u_grant (
        .cpu_valid (cpu_valid),
        .dma_valid (dma_valid),
        .state     (state),
        .burst_cnt (burst_cnt),
`ifdef DRAM_ARB_RR_EN
        .last_dma  (last_dma),
`else
        .wait_cnt  (wait_cnt),
`endif
        .grant     (grant_raw)
    );

    // Grants are combinational from valid, so they are masked while reset is
    // held to keep every output at 0.
    assign grant     = rst ? 2'b00 : grant_raw;
    assign cpu_ready = grant[PORT_CPU];
    assign dma_ready = grant[PORT_DMA];
    assign cpu_beat  = cpu_valid && cpu_ready;
    assign dma_beat  = dma_valid && dma_ready;

    always_comb begin
        dram_adr  = '0;
        dram_op   = OP_BYTE;
        dram_we   = 1'b0;
        dram_wdin = '0;
        if (grant[PORT_CPU]) begin
            dram_adr  = cpu_adr;
            dram_op   = cpu_op;
            dram_we   = cpu_we && cpu_valid;
            dram_wdin = cpu_wdata;
        end else if (grant[PORT_DMA]) begin
            dram_adr  = dma_adr;
            dram_op   = dma_op;
            dram_we   = dma_we && dma_valid;
            dram_wdin = dma_wdata;
        end
    end

    assign cpu_rvalid = rd_cpu;
    assign dma_rvalid = rd_dma;
    assign rdata      = rst ? 32'd0 : dram_rdo;

    always_comb begin
        state_next = ST_IDLE;
        if (dma_beat)      state_next = dma_lock ? ST_BURST : ST_DMA;
        else if (cpu_beat) state_next = ST_CPU;

        // A burst that has hit its limit restarts from zero; any cycle that
        // is not a locked DMA beat drops the lock.
        burst_base     = (burst_cnt >= BURST_LIM) ? '0 : burst_cnt;
        burst_cnt_next = (dma_beat && dma_lock) ? burst_base + 1'b1 : '0;

`ifdef DRAM_ARB_RR_EN
        last_dma_next = last_dma;
        if (dma_beat)      last_dma_next = 1'b1;
        else if (cpu_beat) last_dma_next = 1'b0;
`else
        wait_cnt_next = wait_cnt;
        if (dma_beat)
            wait_cnt_next = '0;
        else if (dma_valid && !dma_ready && wait_cnt != WAIT_LIM)
            wait_cnt_next = wait_cnt + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            rd_cpu    <= 1'b0;
            rd_dma    <= 1'b0;
`ifdef DRAM_ARB_RR_EN
            last_dma  <= 1'b1;
`else
            wait_cnt  <= '0;
`endif
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            rd_cpu    <= cpu_beat && !cpu_we;
            rd_dma    <= dma_beat && !dma_we;
`ifdef DRAM_ARB_RR_EN
            last_dma  <= last_dma_next;
`else
            wait_cnt  <= wait_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed bench for dram_arbiter with a behavioural DRAM
// (one-cycle read latency, word array preloaded with 0xA0000000 | address).
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
    logic [1:0]  cpu_op;
    logic [31:0] cpu_adr, cpu_wdata;
    logic        dma_valid, dma_ready, dma_we, dma_lock, dma_rvalid;
    logic [1:0]  dma_op;
    logic [31:0] dma_adr, dma_wdata;
    logic [31:0] rdata, dram_adr, dram_wdin, dram_rdo;
    logic [1:0]  dram_op;
    logic        dram_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.MAX_BURST(8), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_op(cpu_op), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rvalid(cpu_rvalid),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
        .dma_op(dma_op), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_rvalid(dma_rvalid),
        .rdata(rdata),
        .dram_adr(dram_adr), .dram_op(dram_op), .dram_we(dram_we),
        .dram_wdin(dram_wdin), .dram_rdo(dram_rdo)
    );

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
        end else if (dram_we) begin
            mem[dram_adr[9:2]] <= dram_wdin;
        end
        dram_rdo <= mem[dram_adr[9:2]];
    end

    typedef struct {
        logic        cv, cw;
        logic [1:0]  cop;
        logic [31:0] ca, cd;
        logic        dv, dw;
        logic [31:0] da;
        logic        e_crdy, e_drdy;
        logic [31:0] e_adr;
        logic        e_we;
        logic [1:0]  e_op;
        logic [31:0] e_wdin;
        logic        e_crv, e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_we = 0; cpu_op = 2'b10; cpu_adr = 0; cpu_wdata = 0;
        dma_valid = 0; dma_we = 0; dma_op = 2'b10; dma_adr = 0; dma_wdata = 0;
        dma_lock = 0;
    endtask

    task automatic both_read(input logic [31:0] ca, input logic [31:0] da);
        cpu_valid = 1; cpu_we = 0; cpu_adr = ca;
        dma_valid = 1; dma_we = 0; dma_adr = da; dma_lock = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cpu_ready"},  32'(cpu_ready),  32'd0);
        chk({tag, " dma_ready"},  32'(dma_ready),  32'd0);
        chk({tag, " dram_we"},    32'(dram_we),    32'd0);
        chk({tag, " dram_adr"},   dram_adr,        32'd0);
        chk({tag, " dram_wdin"},  dram_wdin,       32'd0);
        chk({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, " dma_rvalid"}, 32'(dma_rvalid), 32'd0);
        chk({tag, " rdata"},      rdata,           32'd0);
    endtask

    initial begin
        //            cv cw cop    ca       cd            dv dw da       crdy drdy adr      we op     wdin          crv drv rdata
        vecs[0] = '{1, 0, 2'b00, 32'h100, 32'h0,        0, 0, 32'h0,  1, 0, 32'h100, 0, 2'b00, 32'h0,        0, 0, 32'h0};
        vecs[1] = '{0, 0, 2'b10, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   0, 2'b00, 32'h0,        1, 0, 32'hA000_0100};
        vecs[2] = '{1, 1, 2'b10, 32'h40,  32'hDEADBEEF, 0, 0, 32'h0,  1, 0, 32'h40,  1, 2'b10, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[3] = '{0, 0, 2'b10, 32'h0,   32'h0,        1, 0, 32'h40, 0, 1, 32'h40,  0, 2'b10, 32'h0,        0, 0, 32'h0};
        vecs[4] = '{1, 1, 2'b10, 32'h44,  32'h12345678, 0, 0, 32'h0,  1, 0, 32'h44,  1, 2'b10, 32'h12345678, 0, 1, 32'hDEADBEEF};
        vecs[5] = '{0, 0, 2'b10, 32'h0,   32'h0,        1, 0, 32'h44, 0, 1, 32'h44,  0, 2'b10, 32'h0,        0, 0, 32'h0};
        vecs[6] = '{1, 0, 2'b01, 32'h8,   32'h0,        0, 0, 32'h0,  1, 0, 32'h8,   0, 2'b01, 32'h0,        0, 1, 32'h12345678};
        vecs[7] = '{0, 0, 2'b10, 32'h0,   32'h0,        1, 0, 32'h10, 0, 1, 32'h10,  0, 2'b10, 32'h0,        1, 0, 32'hA000_0008};
        vecs[8] = '{0, 0, 2'b10, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   0, 2'b00, 32'h0,        0, 1, 32'hA000_0010};
        vecs[9] = '{0, 0, 2'b10, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 32'h0};

        // Reset with requests present: everything must stay at 0.
        rst = 1;
        idle_inputs();
        both_read(32'h55, 32'h66);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 0;
        idle_inputs();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_valid = vecs[i].cv; cpu_we = vecs[i].cw; cpu_op = vecs[i].cop;
            cpu_adr = vecs[i].ca; cpu_wdata = vecs[i].cd;
            dma_valid = vecs[i].dv; dma_we = vecs[i].dw; dma_adr = vecs[i].da;
            dma_op = 2'b10; dma_lock = 0;
            #2;
            chk($sformatf("v%0d cpu_ready", i),  32'(cpu_ready),  32'(vecs[i].e_crdy));
            chk($sformatf("v%0d dma_ready", i),  32'(dma_ready),  32'(vecs[i].e_drdy));
            chk($sformatf("v%0d dram_adr", i),   dram_adr,        vecs[i].e_adr);
            chk($sformatf("v%0d dram_we", i),    32'(dram_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d dram_op", i),    32'(dram_op),    32'(vecs[i].e_op));
            chk($sformatf("v%0d dram_wdin", i),  dram_wdin,       vecs[i].e_wdin);
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].e_drv));
            if (vecs[i].e_crv || vecs[i].e_drv)
                chk($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
        end

`ifndef DRAM_ARB_RR_EN
        // Starvation: CPU wins 15 times, DMA forced through on the 16th,
        // then the cleared wait count hands priority back to the CPU.
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            both_read(32'h200, 32'h300);
            #2;
            chk($sformatf("starve%0d cpu_ready", k), 32'(cpu_ready), (k == 16) ? 32'd0 : 32'd1);
            chk($sformatf("starve%0d dma_ready", k), 32'(dma_ready), (k == 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        idle_inputs();
`endif

        // Locked burst: 8 DMA beats despite a waiting CPU, then the CPU.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            cpu_valid = (k > 1); cpu_we = 0; cpu_adr = 32'h80;
            dma_valid = 1; dma_we = 1; dma_adr = 32'h300 + 32'(k * 4);
            dma_wdata = 32'(k); dma_lock = 1;
            #2;
            chk($sformatf("burst%0d cpu_ready", k), 32'(cpu_ready), (k <= 8) ? 32'd0 : 32'd1);
            chk($sformatf("burst%0d dma_ready", k), 32'(dma_ready), (k <= 8) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        #2;
        chk("burst cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("burst rdata", rdata, 32'hA000_0080);
        chk("burst dma_rvalid", 32'(dma_rvalid), 32'd0);

        // Reset landing right after a DMA read beat drops the response.
        @(negedge clk);
        dma_valid = 1; dma_we = 0; dma_adr = 32'h10;
        #2;
        chk("rstmid dma_ready", 32'(dma_ready), 32'd1);
        #2;
        rst = 1;
        cpu_valid = 1; cpu_adr = 32'h20;
        @(posedge clk); #1;
        chk_reset_outputs("rstmid");
        @(negedge clk); #2;
        chk("rstmid hold dma_rvalid", 32'(dma_rvalid), 32'd0);
        @(negedge clk);
        rst = 0;
        both_read(32'h20, 32'h24);
        #2;
        chk("postrst cpu_ready", 32'(cpu_ready), 32'd1);
        chk("postrst dma_ready", 32'(dma_ready), 32'd0);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("postrst dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("postrst cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("postrst rdata", rdata, 32'hA000_0020);

`ifdef DRAM_ARB_RR_EN
        // Round robin from reset: CPU, DMA, CPU, DMA ...
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            both_read(32'h30, 32'h34);
            #2;
            chk($sformatf("rr%0d cpu_ready", k), 32'(cpu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d dma_ready", k), 32'(dma_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        idle_inputs();
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
